ins_queue: RTL and testbench
============================

// Module: ins_queue
//
// PURPOSE
// Parametrised instruction register/queue; successor to the single-entry
// load-enabled instruction register. Buffers up to DEPTH instruction words
// between fetch (producer) and decode (consumer). Head word is presented on a
// registered output that holds its value while not advanced. Decode stalls and
// pipeline flushes do not lose or duplicate words.
//
// PARAMETERS
// n      16  instruction word width in bits (>=1)
// DEPTH  4   total entries including the head; power of 2, >=2
// CW     $clog2(DEPTH+1)  width of count (localparam, not overridable)
//
// PORTS
// clk        in   1      rising-edge clock
// rst_n      in   1      asynchronous active-low reset
// in         in   n      instruction word from fetch
// in_valid   in   1      fetch offers `in` this cycle
// in_ready   out  1      queue accepts `in` this cycle
// load       in   1      decode consumes head word (advance request)
// flush      in   1      synchronous discard of all held words
// out        out  n      head instruction word (registered)
// out_valid  out  1      `out` holds a valid, unconsumed word
// count      out  CW     number of valid words held (0..DEPTH)
//
// BEHAVIOUR
// - Reset (rst_n=0, async): out=0, out_valid=0, count=0, rd/wr ptrs=0,
//   storage contents don't-care. Reset mid-transfer drops all words.
// - push = in_valid & in_ready; pop = load & out_valid (load with
//   out_valid=0 is ignored, no state change).
// - in_ready = (count != DEPTH) & ~flush; depends only on registered count
//   and flush, never on load (no comb path load->in_ready).
// - Full (count==DEPTH): in_ready=0 even if pop this cycle; word retried.
// - Latency: push into empty queue -> out=in, out_valid=1 next edge (1 cycle).
// - Pop with count>=2: out takes next-oldest word next edge; out_valid stays 1.
// - Pop with count==1 and no push: out_valid=0 next edge; out retains last
//   value (not cleared).
// - Pop + push, same cycle, count==1: out=in next edge, out_valid=1, count=1.
// - Pop + push, count>=2: out advances to next-oldest; new word queued; count
//   unchanged. Order is strict FIFO.
// - No pop, no push: out, out_valid, count hold (load=0 behaves as old IR hold).
// - count: +1 on push only, -1 on pop only, unchanged on both/neither.
// - Pointers: log2(DEPTH)-bit, wrap modulo DEPTH without special casing.
// - flush=1 (priority over push/pop): next edge count=0, out_valid=0,
//   pointers reset to 0, out retains value; concurrent push dropped
//   (in_ready already 0), concurrent load ignored.
// - Invariants: out_valid == (count!=0); count<=DEPTH; no X on outputs after
//   reset.
//
// TESTING
// 1 Reset: rst_n low mid-cycle with count=3 -> out=0, out_valid=0, count=0
//   immediately (before next edge); in_ready=1 after release.
// 2 Fill n=16,DEPTH=4: push 0x1111,0x2222,0x3333,0x4444, load=0 -> count=4,
//   in_ready=0, out=0x1111; 5th word 0x5555 held off until one pop.
// 3 Drain: load=1 for 5 cycles from full -> out 0x1111,0x2222,0x3333,0x4444,
//   then out_valid=0 with out=0x4444 held; count 4,3,2,1,0.
// 4 Simultaneous: count=1 (0xAAAA), load=1 + push 0xBBBB -> out=0xBBBB,
//   count=1; repeat 10 cycles streaming -> zero bubbles, order preserved.
// 5 Flush: count=3, flush=1 with in_valid=1, load=1 -> count=0,
//   out_valid=0, pushed word absent; next push 0xCCCC appears on out 1 cycle
//   later.
// 6 Wrap/random: 2000 cycles random in_valid/load/flush (flush 2%) vs
//   scoreboard FIFO; pointer wrap exercised >100 times, no mismatch.

Source files
------------

// File: rtl/ins_queue_if.sv
// ins_queue_if: the fetch->queue->decode signals of the instruction queue.
//   in/in_valid/in_ready : producer side (fetch offers a word, queue accepts)
//   load/flush           : consumer controls (advance the head, discard all)
//   out/out_valid/count  : registered head word, its valid flag, occupancy
// The slave modport is the queue. The master modport is whoever drives
// fetch and decode.
interface ins_queue_if #(
  parameter int n     = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [n-1:0]  in;
  logic          in_valid;
  logic          in_ready;
  logic          load;
  logic          flush;
  logic [n-1:0]  out;
  logic          out_valid;
  logic [CW-1:0] count;

  modport slave (
    input  in, in_valid, load, flush,
    output in_ready, out, out_valid, count
  );

  modport master (
    output in, in_valid, load, flush,
    input  in_ready, out, out_valid, count
  );
endinterface

// File: rtl/ins_queue.sv
// ins_queue: a DEPTH-entry instruction FIFO between fetch and decode.
// It replaces the single-entry, load-enabled instruction register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset. Clears out, count and pointers.
//   q     : ins_queue_if.slave. Carries the fetch handshake, load (advance),
//           flush, the registered head word out/out_valid, and count.
// Every held word, the head included, sits in mem. The out register is a
// registered copy of the current head, so it holds steady while no pop occurs.
// It also keeps its last value after the queue drains or is flushed.
module ins_queue #(
  parameter int n     = 16,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  ins_queue_if.slave  q
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [n-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_inc;
  logic [CW-1:0] count_r, count_next;
  logic [n-1:0]  out_r, out_next;
  logic          in_ready, push, pop;

  // in_ready looks only at the registered count and at flush. There is no
  // path from load, so a full queue refuses a word even in a cycle that pops.
  assign in_ready   = (count_r != CW'(DEPTH)) & ~q.flush;
  assign push       = q.in_valid & in_ready;
  assign pop        = q.load & (count_r != '0) & ~q.flush;
  assign rd_ptr_inc = rd_ptr + PW'(1);

  always_comb begin
    out_next = out_r;
    if (!q.flush) begin
      if (pop && (count_r > CW'(1)))
        out_next = mem[rd_ptr_inc];
      // An empty queue, or one whose single word is being popped, shows the
      // incoming word directly. This gives 1-cycle latency with no bubble.
      else if (push && ((count_r == '0) || pop))
        out_next = q.in;
    end
  end

  always_comb begin
    count_next = count_r;
    if (q.flush)
      count_next = '0;
    else if (push && !pop)
      count_next = count_r + CW'(1);
    else if (pop && !push)
      count_next = count_r - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_r <= '0;
      out_r   <= '0;
    end else begin
      count_r <= count_next;
      out_r   <= out_next;
      if (q.flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q.in;
  end

  assign q.in_ready  = in_ready;
  assign q.out       = out_r;
  assign q.out_valid = (count_r != '0);
  assign q.count     = count_r;
endmodule

// File: tb/tb_ins_queue.sv
module tb_ins_queue;
  localparam int N = 16;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ins_queue_if #(.n(N), .DEPTH(D)) qif ();

  ins_queue #(.n(N), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (qif.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic         iv;
    logic [N-1:0] din;
    logic         ld;
    logic         fl;
    logic         rdy;
    logic [N-1:0] out;
    logic         ov;
    logic [2:0]   cnt;
  } vec_t;

  vec_t tbl[20];

  // Drive at the negedge, check in_ready before the posedge, then check the
  // registered outputs 1 time unit after the posedge.
  task automatic step(input logic iv, input logic [N-1:0] din, input logic ld,
                      input logic fl, input logic rdy, input logic [N-1:0] eout,
                      input logic eov, input logic [2:0] ecnt, input string tag);
    @(negedge clk);
    qif.in_valid = iv; qif.in = din; qif.load = ld; qif.flush = fl;
    #1;
    chk({tag, ".in_ready"}, 32'(qif.in_ready), 32'(rdy));
    @(posedge clk); #1;
    chk({tag, ".out"}, 32'(qif.out), 32'(eout));
    chk({tag, ".out_valid"}, 32'(qif.out_valid), 32'(eov));
    chk({tag, ".count"}, 32'(qif.count), 32'(ecnt));
  endtask

  logic [N-1:0] mq[$];
  logic [N-1:0] mout;
  logic         r_iv, r_ld, r_fl, e_rdy;
  logic [N-1:0] r_din;

  initial begin
    qif.in = '0; qif.in_valid = 1'b0; qif.load = 1'b0; qif.flush = 1'b0;
    #1;
    chk("reset.out", 32'(qif.out), 32'h0);
    chk("reset.out_valid", 32'(qif.out_valid), 32'h0);
    chk("reset.count", 32'(qif.count), 32'h0);
    #12 rst_n = 1'b1;

    //              iv din       ld fl  rdy out      ov cnt
    tbl[0]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b1, 3'd1};
    tbl[1]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b1, 3'd2};
    tbl[2]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b1, 3'd3};
    tbl[3]  = '{1'b1, 16'h4444, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b1, 3'd4};
    tbl[4]  = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h1111, 1'b1, 3'd4};
    tbl[5]  = '{1'b1, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h2222, 1'b1, 3'd3};
    tbl[6]  = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 16'h2222, 1'b1, 3'd4};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h3333, 1'b1, 3'd3};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h4444, 1'b1, 3'd2};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h5555, 1'b1, 3'd1};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h5555, 1'b0, 3'd0};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h5555, 1'b0, 3'd0};
    tbl[12] = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b1, 3'd1};
    tbl[13] = '{1'b1, 16'hBBBB, 1'b1, 1'b0, 1'b1, 16'hBBBB, 1'b1, 3'd1};
    tbl[14] = '{1'b1, 16'hCCCC, 1'b1, 1'b0, 1'b1, 16'hCCCC, 1'b1, 3'd1};
    tbl[15] = '{1'b1, 16'hDDDD, 1'b0, 1'b0, 1'b1, 16'hCCCC, 1'b1, 3'd2};
    tbl[16] = '{1'b1, 16'hEEEE, 1'b1, 1'b0, 1'b1, 16'hDDDD, 1'b1, 3'd2};
    tbl[17] = '{1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'hDDDD, 1'b0, 3'd0};
    tbl[18] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 3'd1};
    tbl[19] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 3'd1};

    for (int i = 0; i < 20; i++)
      step(tbl[i].iv, tbl[i].din, tbl[i].ld, tbl[i].fl, tbl[i].rdy,
           tbl[i].out, tbl[i].ov, tbl[i].cnt, $sformatf("vec%0d", i));

    // Streaming: load and push together every cycle, with no bubbles.
    for (int i = 0; i < 10; i++)
      step(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0, 1'b1, 16'h0100 + 16'(i), 1'b1, 3'd1,
           $sformatf("stream%0d", i));

    // Flush at count 3 while a push and a load are also requested.
    step(1'b1, 16'h0201, 1'b0, 1'b0, 1'b1, 16'h0109, 1'b1, 3'd2, "fl_fill0");
    step(1'b1, 16'h0202, 1'b0, 1'b0, 1'b1, 16'h0109, 1'b1, 3'd3, "fl_fill1");
    step(1'b1, 16'h7777, 1'b1, 1'b1, 1'b0, 16'h0109, 1'b0, 3'd0, "flush");
    step(1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b1, 16'hCCCC, 1'b1, 3'd1, "post_flush");
    step(1'b1, 16'h0301, 1'b0, 1'b0, 1'b1, 16'hCCCC, 1'b1, 3'd2, "rst_fill0");
    step(1'b1, 16'h0302, 1'b0, 1'b0, 1'b1, 16'hCCCC, 1'b1, 3'd3, "rst_fill1");

    // Assert reset in the middle of a cycle. It must act before the next edge.
    @(negedge clk);
    qif.in_valid = 1'b0; qif.load = 1'b0; qif.flush = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst.out", 32'(qif.out), 32'h0);
    chk("mid_rst.out_valid", 32'(qif.out_valid), 32'h0);
    chk("mid_rst.count", 32'(qif.count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst.in_ready", 32'(qif.in_ready), 32'h1);
    @(posedge clk); #1;
    chk("post_rst.count", 32'(qif.count), 32'h0);

    // Random traffic, checked against a queue model.
    mq.delete();
    mout = '0;
    for (int c = 0; c < 2000; c++) begin
      r_iv  = ($urandom_range(99) < 60);
      r_ld  = ($urandom_range(99) < 50);
      r_fl  = ($urandom_range(99) < 2);
      r_din = N'($urandom);
      @(negedge clk);
      qif.in_valid = r_iv; qif.in = r_din; qif.load = r_ld; qif.flush = r_fl;
      e_rdy = (mq.size() != D) && !r_fl;
      #1 chk("rnd.in_ready", 32'(qif.in_ready), 32'(e_rdy));
      if (r_fl) begin
        mq.delete();
      end else begin
        if (r_ld && mq.size() > 0) void'(mq.pop_front());
        if (r_iv && e_rdy) mq.push_back(r_din);
      end
      if (mq.size() > 0) mout = mq[0];
      @(posedge clk); #1;
      chk("rnd.out", 32'(qif.out), 32'(mout));
      chk("rnd.out_valid", 32'(qif.out_valid), 32'(mq.size() != 0));
      chk("rnd.count", 32'(qif.count), 32'(mq.size()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
